pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter controller for the pipelined MIPS core. It owns the PC register and selects next-PC among sequential, branch, jump and jump-register targets. The branch target is built from the sign-extended 32-bit branch offset produced in ID. It also gates pipeline advance for hazard stalls and for debug-unit continuous/single-step execution, and it signals IF/ID flushes and program halt.

## Interface
Parameters:
- DATA_WIDTH, 32, PC and target width
- JUMP_IDX_WIDTH, 26, J-type index width
- PC_RESET, 32'h0000_0000, PC value after reset

Ports:
- i_clk  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_enable  in  1  debug unit run enable (level)
- i_step_mode  in  1  0 = continuous, 1 = single-step
- i_step  in  1  step request (level; edge-detected internally)
- i_stall  in  1  load-use stall from hazard unit; ID holds
- i_halt  in  1  HALT decoded in ID
- i_branch_taken  in  1  branch in ID resolved taken
- i_branchoffset  in  DATA_WIDTH  sign-extended immediate from ID
- i_id_pc_plus4  in  DATA_WIDTH  PC+4 of instruction in ID
- i_jump  in  1  J/JAL in ID
- i_jump_index  in  JUMP_IDX_WIDTH  instr[25:0]
- i_jump_reg  in  1  JR/JALR in ID
- i_jr_target  in  DATA_WIDTH  rs value
- o_pc  out  DATA_WIDTH  fetch address (registered)
- o_pc_plus4  out  DATA_WIDTH  o_pc + 4
- o_pipe_enable  out  1  global pipeline advance this cycle
- o_ifid_write  out  1  IF/ID register write enable
- o_flush  out  1  clear IF/ID this cycle
- o_halted  out  1  program halted (registered)
- o_cycle_count  out  DATA_WIDTH  advanced cycles since reset

## Operation
- States: IDLE, RUN, HALTED. Reset -> IDLE. IDLE -> RUN when i_enable=1, with no advance in that cycle. RUN -> HALTED on an accepted halt. HALTED is exited only by reset. RUN with i_enable=0 stays in RUN with no advance.
- Step edge: step_pulse = i_step & ~i_step_q. i_step_q resets to 0.
- adv = (state==RUN) & i_enable & (~i_step_mode | step_pulse). o_pipe_enable = adv.
- Next-PC priority when adv=1:
  - i_stall: PC held, o_ifid_write=0, no flush. ID-sourced requests are ignored.
  - i_halt: PC held, o_flush=1, state -> HALTED.
  - i_jump_reg: PC <= {i_jr_target[31:2], 2'b00}, o_flush=1.
  - i_jump: PC <= {i_id_pc_plus4[31:28], i_jump_index, 2'b00}, o_flush=1.
  - i_branch_taken: PC <= i_id_pc_plus4 + (i_branchoffset << 2), modulo 2^32, o_flush=1.
  - otherwise: PC <= o_pc + 4, wrapping at 2^32.
- adv=0: all registers except i_step_q hold. o_flush=0 and o_ifid_write=0.
- o_ifid_write = adv & ~i_stall.
- o_cycle_count increments on every adv cycle, stalls included, and wraps.
- Reset values: o_pc=PC_RESET, o_pc_plus4=PC_RESET+4, o_cycle_count=0, o_halted=0, o_flush=0, o_pipe_enable=0, o_ifid_write=0.

## Timing
- o_pc, o_halted and o_cycle_count are registered and update on the rising edge where adv=1.
- o_flush, o_pipe_enable and o_ifid_write are combinational from the current state and inputs. They are valid in the same cycle as the redirect decision, so IF/ID captures a bubble on the same edge that PC loads the target.
- Redirect latency: the target appears on o_pc one cycle after the request.
- Simultaneous events:
  - stall beats every redirect;
  - halt beats jr, j and branch;
  - the step pulse and i_enable fall in the same cycle give no advance.
- Asynchronous reset mid-run returns the block to IDLE immediately, with no partial update.

## Structure
- Shared package mips_pkg: state enum (IDLE/RUN/HALTED), PC_RESET, PC_INC=4.
- Sub-module step_edge_detect: a one-register rising-edge detector for i_step, reusable for other debug-unit pulses.
- Next-PC mux and adder stay inline.

## Test plan
- Reset then i_enable=1 continuous: o_pc 0x0 → 0x4 → 0x8 → 0xC. o_cycle_count=3 after three advances. A reset pulse mid-run gives o_pc=0, o_cycle_count=0, IDLE.
- Branch: i_id_pc_plus4=0x10, i_branchoffset=0xFFFF_FFFE, taken → o_flush=1 that cycle, next o_pc=0x08. With offset 0x0000_0003 → 0x1C.
- Jump/JR: i_id_pc_plus4=0x4000_0010, index=0x000_0040 → o_pc=0x4000_0100. i_jr_target=0x0000_0123 → o_pc=0x0000_0120. Both set o_flush=1.
- Stall with branch_taken the same cycle → o_pc held, o_flush=0, o_ifid_write=0, o_cycle_count +1. The next unstalled cycle takes the branch.
- Step mode, i_step high for 3 cycles → exactly one advance (o_pc +4). Low then high again → one more advance.
- i_halt while in RUN → o_flush=1, then o_halted=1 next cycle and o_pc frozen. Further i_step/i_enable changes have no effect until reset.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the MIPS core
//
// Purpose : sequencer state encoding and program-counter constants.
// Ports   : none (package).

package mips_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } seq_state_t;

   localparam logic [31:0] PC_RESET = 32'h0000_0000;
   localparam logic [31:0] PC_INC   = 32'd4;

endpackage

// File: rtl/step_edge_detect.sv
// rtl/step_edge_detect.sv - single-register rising-edge detector
//
// Purpose : turns a level request into a one-cycle pulse on its rising edge.
// Ports   : i_clk   - system clock, rising edge
//           i_reset - asynchronous, active-high reset
//           i_level - level input to watch
//           o_pulse - high for the first cycle i_level is seen high

module step_edge_detect (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_level,
   output logic o_pulse
);

   logic level_q;

   // The history register tracks the input every cycle, independent of
   // whether the pipeline advances, so a held level yields only one pulse.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         level_q <= 1'b0;
      end else begin
         level_q <= i_level;
      end
   end

   assign o_pulse = i_level & ~level_q;

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter controller for the pipelined MIPS core
//
// Purpose : owns the PC, picks next-PC (sequential/branch/jump/jump-register),
//           gates pipeline advance for stalls and debug run/step, and
//           reports IF/ID flushes and program halt.
// Ports   : i_clk, i_reset          - clock / async active-high reset
//           i_enable, i_step_mode,
//           i_step                  - debug-unit run control
//           i_stall                 - load-use stall from hazard unit
//           i_halt                  - HALT decoded in ID
//           i_branch_taken,
//           i_branchoffset,
//           i_id_pc_plus4           - branch redirect inputs from ID
//           i_jump, i_jump_index    - J/JAL redirect inputs
//           i_jump_reg, i_jr_target - JR/JALR redirect inputs
//           o_pc, o_pc_plus4        - fetch address and its successor
//           o_pipe_enable           - pipeline advances this cycle
//           o_ifid_write            - IF/ID write enable
//           o_flush                 - clear IF/ID this cycle
//           o_halted                - program halted
//           o_cycle_count           - advanced cycles since reset

module pc_sequencer
   import mips_pkg::*;
#(
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    JUMP_IDX_WIDTH = 26,
   parameter logic [DATA_WIDTH-1:0] PC_RESET       = mips_pkg::PC_RESET
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_enable,
   input  logic                      i_step_mode,
   input  logic                      i_step,
   input  logic                      i_stall,
   input  logic                      i_halt,
   input  logic                      i_branch_taken,
   input  logic [DATA_WIDTH-1:0]     i_branchoffset,
   input  logic [DATA_WIDTH-1:0]     i_id_pc_plus4,
   input  logic                      i_jump,
   input  logic [JUMP_IDX_WIDTH-1:0] i_jump_index,
   input  logic                      i_jump_reg,
   input  logic [DATA_WIDTH-1:0]     i_jr_target,
   output logic [DATA_WIDTH-1:0]     o_pc,
   output logic [DATA_WIDTH-1:0]     o_pc_plus4,
   output logic                      o_pipe_enable,
   output logic                      o_ifid_write,
   output logic                      o_flush,
   output logic                      o_halted,
   output logic [DATA_WIDTH-1:0]     o_cycle_count
);

   localparam logic [DATA_WIDTH-1:0] INC      = DATA_WIDTH'(PC_INC);
   localparam logic [DATA_WIDTH-1:0] WORD_MSK = ~DATA_WIDTH'(3);

   seq_state_t            state_q, state_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0] count_q, count_d;
   logic                  halted_q, halted_d;
   logic                  step_pulse;
   logic                  adv;

   step_edge_detect u_step_edge (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_level (i_step),
      .o_pulse (step_pulse)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q  <= IDLE;
         pc_q     <= PC_RESET;
         count_q  <= '0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         count_q  <= count_d;
         halted_q <= halted_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      count_d      = count_q;
      halted_d     = halted_q;
      o_flush      = 1'b0;
      o_ifid_write = 1'b0;

      adv = (state_q == RUN) & i_enable & (~i_step_mode | step_pulse);

      case (state_q)
         IDLE: begin
            // Entering RUN never advances in the same cycle.
            if (i_enable) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (adv) begin
               count_d      = count_q + 1'b1;
               o_ifid_write = ~i_stall;
               // A stalled ID holds its instruction, so any redirect it
               // requests is re-presented on the next unstalled cycle.
               if (i_stall) begin
                  pc_d = pc_q;
               end else if (i_halt) begin
                  o_flush  = 1'b1;
                  state_d  = HALTED;
                  halted_d = 1'b1;
               end else if (i_jump_reg) begin
                  o_flush = 1'b1;
                  pc_d    = i_jr_target & WORD_MSK;
               end else if (i_jump) begin
                  o_flush = 1'b1;
                  pc_d    = {i_id_pc_plus4[DATA_WIDTH-1:DATA_WIDTH-4], i_jump_index, 2'b00};
               end else if (i_branch_taken) begin
                  o_flush = 1'b1;
                  pc_d    = i_id_pc_plus4 + (i_branchoffset << 2);
               end else begin
                  pc_d = pc_q + INC;
               end
            end
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign o_pc          = pc_q;
   assign o_pc_plus4    = pc_q + INC;
   assign o_pipe_enable = adv;
   assign o_halted      = halted_q;
   assign o_cycle_count = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard testbench for pc_sequencer

module tb_pc_sequencer;

   logic        clk;
   logic        rst;
   logic        enable, step_mode, step, stall, halt, branch_taken;
   logic [31:0] branchoffset, id_pc_plus4, jr_target;
   logic        jump, jump_reg;
   logic [25:0] jump_index;
   logic [31:0] pc, pc_plus4, cycle_count;
   logic        pipe_enable, ifid_write, flush, halted;

   int tests_run = 0;
   int tests_failed = 0;

   typedef struct {
      logic [31:0] pc;
      logic        fl;
      logic        ifw;
      logic [31:0] cc;
   } exp_t;

   exp_t exp_q[$];

   pc_sequencer dut (
      .i_clk          (clk),
      .i_reset        (rst),
      .i_enable       (enable),
      .i_step_mode    (step_mode),
      .i_step         (step),
      .i_stall        (stall),
      .i_halt         (halt),
      .i_branch_taken (branch_taken),
      .i_branchoffset (branchoffset),
      .i_id_pc_plus4  (id_pc_plus4),
      .i_jump         (jump),
      .i_jump_index   (jump_index),
      .i_jump_reg     (jump_reg),
      .i_jr_target    (jr_target),
      .o_pc           (pc),
      .o_pc_plus4     (pc_plus4),
      .o_pipe_enable  (pipe_enable),
      .o_ifid_write   (ifid_write),
      .o_flush        (flush),
      .o_halted       (halted),
      .o_cycle_count  (cycle_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every advancing cycle must match the next queued expectation.
   always @(negedge clk) begin
      if (!rst && pipe_enable === 1'b1) begin
         if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_advance: pc=0x%08h cycle_count=%0d", pc, cycle_count);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("adv_pc", pc, e.pc);
            check("adv_flush", {31'd0, flush}, {31'd0, e.fl});
            check("adv_ifid_write", {31'd0, ifid_write}, {31'd0, e.ifw});
            check("adv_cycle_count", cycle_count, e.cc);
         end
      end
   end

   task automatic clear_id();
      stall = 0; halt = 0; branch_taken = 0; jump = 0; jump_reg = 0;
      branchoffset = 0; id_pc_plus4 = 0; jump_index = 0; jr_target = 0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc_adv(input logic [31:0] p, input logic fl, input logic ifw, input logic [31:0] cc);
      exp_t e;
      e.pc = p; e.fl = fl; e.ifw = ifw; e.cc = cc;
      exp_q.push_back(e);
      next_cycle();
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1; enable = 0; step_mode = 0; step = 0;
      clear_id();
      next_cycle();
      next_cycle();
      check("reset_pc", pc, 32'h0);
      check("reset_pc_plus4", pc_plus4, 32'h4);
      check("reset_cycle_count", cycle_count, 32'h0);
      check("reset_halted", {31'd0, halted}, 32'h0);
      check("reset_flush", {31'd0, flush}, 32'h0);
      check("reset_pipe_enable", {31'd0, pipe_enable}, 32'h0);
      check("reset_ifid_write", {31'd0, ifid_write}, 32'h0);
      rst = 0;
      next_cycle();

      // IDLE -> RUN, no advance
      enable = 1;
      next_cycle();
      cyc_adv(32'h0, 0, 1, 0);
      cyc_adv(32'h4, 0, 1, 1);
      cyc_adv(32'h8, 0, 1, 2);
      check("seq_pc_after3", pc, 32'hC);
      check("seq_count_after3", cycle_count, 32'd3);

      // backward branch
      id_pc_plus4 = 32'h10; branchoffset = 32'hFFFF_FFFE; branch_taken = 1;
      cyc_adv(32'hC, 1, 1, 3);
      // forward branch
      branchoffset = 32'h3;
      cyc_adv(32'h8, 1, 1, 4);
      clear_id();
      // jump
      jump = 1; id_pc_plus4 = 32'h4000_0010; jump_index = 26'h40;
      cyc_adv(32'h1C, 1, 1, 5);
      clear_id();
      // jump register
      jump_reg = 1; jr_target = 32'h0000_0123;
      cyc_adv(32'h4000_0100, 1, 1, 6);
      clear_id();
      // stall beats branch, then branch taken
      stall = 1; branch_taken = 1; id_pc_plus4 = 32'h10; branchoffset = 32'h3;
      cyc_adv(32'h120, 0, 0, 7);
      stall = 0;
      cyc_adv(32'h120, 1, 1, 8);
      clear_id();
      // jr beats j and branch
      jump_reg = 1; jr_target = 32'h200; jump = 1; jump_index = 26'h1;
      branch_taken = 1; id_pc_plus4 = 32'h10; branchoffset = 32'h40;
      cyc_adv(32'h1C, 1, 1, 9);
      // j beats branch
      jump_reg = 0;
      cyc_adv(32'h200, 1, 1, 10);
      clear_id();

      // enable low in RUN: no advance
      enable = 0;
      #1;
      check("disabled_pipe_enable", {31'd0, pipe_enable}, 32'h0);
      next_cycle();
      next_cycle();
      check("disabled_pc_held", pc, 32'h4);

      // single-step
      enable = 1; step_mode = 1; step = 0;
      next_cycle();
      step = 1;
      cyc_adv(32'h4, 0, 1, 11);
      next_cycle();
      next_cycle();
      check("step_held_pc", pc, 32'h8);
      step = 0;
      next_cycle();
      step = 1;
      cyc_adv(32'h8, 0, 1, 12);
      step = 0;
      next_cycle();
      // step edge coinciding with enable falling: no advance
      step = 1; enable = 0;
      next_cycle();
      enable = 1;
      next_cycle();
      check("step_enable_fall_pc", pc, 32'hC);
      step = 0;
      next_cycle();
      step = 1;
      cyc_adv(32'hC, 0, 1, 13);
      step = 0; step_mode = 0;

      // stall beats halt, then halt beats jr
      stall = 1; halt = 1;
      cyc_adv(32'h10, 0, 0, 14);
      check("stall_halt_not_halted", {31'd0, halted}, 32'h0);
      stall = 0; jump_reg = 1; jr_target = 32'h300;
      cyc_adv(32'h10, 1, 1, 15);
      clear_id();
      check("halted_set", {31'd0, halted}, 32'h1);
      check("halted_pc", pc, 32'h10);
      check("halted_count", cycle_count, 32'd16);
      step_mode = 1; step = 1;
      next_cycle();
      step = 0; step_mode = 0; enable = 0;
      next_cycle();
      enable = 1;
      #1;
      check("halted_pipe_enable", {31'd0, pipe_enable}, 32'h0);
      next_cycle();
      check("halted_pc_frozen", pc, 32'h10);
      check("halted_count_frozen", cycle_count, 32'd16);

      // asynchronous reset mid-cycle
      #2;
      rst = 1;
      #1;
      check("async_reset_pc", pc, 32'h0);
      check("async_reset_count", cycle_count, 32'h0);
      check("async_reset_halted", {31'd0, halted}, 32'h0);
      check("async_reset_pipe_enable", {31'd0, pipe_enable}, 32'h0);
      next_cycle();
      rst = 0;
      next_cycle();
      cyc_adv(32'h0, 0, 1, 0);
      cyc_adv(32'h4, 0, 1, 1);
      enable = 0;
      next_cycle();
      check("post_reset_pc", pc, 32'h8);
      check("queue_drained", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
